// File: rtl/everloop_frame_fetch.sv
// everloop_frame_fetch: walks the LED frame RAM one byte per serializer request, then holds the latch interval
module everloop_frame_fetch #(
  parameter int N_LEDS = 35,
  parameter int BYTES_PER_LED = 4,
  parameter int ADDR_W = 8,
  parameter int LATCH_CYCLES = 16000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              auto_refresh,
  output logic              ram_rd,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [7:0]        ram_data,
  input  logic              en_rd,
  output logic [7:0]        data_RGB,
  output logic              ack,
  output logic              reset_everloop,
  output logic              busy,
  output logic              frame_done
);
  localparam int FRAME_BYTES = N_LEDS * BYTES_PER_LED;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_BYTES - 1);
  localparam int CW = $clog2(LATCH_CYCLES + 1);
  localparam logic [CW-1:0] LATCH_LAST = CW'(LATCH_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, ARM, FETCH, ACK, STREAM, TAIL, LATCH} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] byte_idx_n;
  logic [CW-1:0] latch_cnt, latch_cnt_n;
  logic start_pend, start_pend_n;
  logic ram_rd_n, ack_n, rev_n, busy_n, frame_done_n;
  logic [7:0] data_n;
  // ram_addr doubles as byte_idx so the read address is always the registered byte index
  // next-state and next-output logic; a start seen while busy is remembered one deep
  always_comb begin
    state_n = state;
    byte_idx_n = ram_addr;
    latch_cnt_n = latch_cnt;
    start_pend_n = start_pend | (busy & start);
    ram_rd_n = 1'b0;
    ack_n = 1'b0;
    data_n = data_RGB;
    rev_n = reset_everloop;
    busy_n = busy;
    frame_done_n = 1'b0;
    case (state)
      IDLE: if (start | start_pend) begin
        state_n = ARM;
        start_pend_n = 1'b0;
        busy_n = 1'b1;
        byte_idx_n = '0;
      end
      ARM, STREAM: if (en_rd) begin
        state_n = FETCH;
        ram_rd_n = 1'b1;
      end
      FETCH: state_n = ACK;
      ACK: begin
        data_n = ram_data;
        ack_n = 1'b1;
        rev_n = 1'b0;
        state_n = (ram_addr == LAST_IDX) ? TAIL : STREAM;
        byte_idx_n = (ram_addr == LAST_IDX) ? ram_addr : ram_addr + ADDR_W'(1);
      end
      TAIL: if (en_rd) begin
        state_n = LATCH;
        rev_n = 1'b1;
        latch_cnt_n = '0;
      end
      LATCH: begin
        latch_cnt_n = latch_cnt + CW'(1);
        if (latch_cnt == LATCH_LAST) begin
          frame_done_n = 1'b1;
          latch_cnt_n = '0;
          if (auto_refresh | start_pend | start) begin
            state_n = ARM;
            byte_idx_n = '0;
            start_pend_n = 1'b0;
          end else begin
            state_n = IDLE;
            busy_n = 1'b0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end
  // state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ram_addr <= '0;
      latch_cnt <= '0;
      start_pend <= 1'b0;
      ram_rd <= 1'b0;
      ack <= 1'b0;
      data_RGB <= '0;
      reset_everloop <= 1'b1;
      busy <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state <= state_n;
      ram_addr <= byte_idx_n;
      latch_cnt <= latch_cnt_n;
      start_pend <= start_pend_n;
      ram_rd <= ram_rd_n;
      ack <= ack_n;
      data_RGB <= data_n;
      reset_everloop <= rev_n;
      busy <= busy_n;
      frame_done <= frame_done_n;
    end
  end
endmodule

// File: tb/tb_everloop_frame_fetch.sv
// tb_everloop_frame_fetch: scoreboard bench for the frame fetcher against a byte-sequence model
module tb_everloop_frame_fetch;
  localparam int NL = 2, BPL = 4, AW = 8, LC = 100;
  localparam int FB = NL * BPL;
  logic clk = 0, rst = 1, start = 0, auto_refresh = 0, en_rd = 0;
  logic ram_rd, ack, reset_everloop, busy, frame_done;
  logic [AW-1:0] ram_addr;
  logic [7:0] ram_data = 0, data_RGB;
  logic [7:0] mem [256];
  logic [7:0] exp_q [$];
  int total = 0, bad = 0, cyc = 0, exp_frames = 0;
  int n_ack = 0, n_rd = 0, n_fd = 0, n_low = 0, rise_cyc = 0;
  int per = 1928, tick = 0;
  logic spur_req = 0, spur_now = 0;
  logic [2:0] en_h = 0;
  logic prev_ack = 0, prev_rev = 1, rst_prev = 1;

  everloop_frame_fetch #(.N_LEDS(NL), .BYTES_PER_LED(BPL), .ADDR_W(AW), .LATCH_CYCLES(LC)) dut (
    .clk(clk), .rst(rst), .start(start), .auto_refresh(auto_refresh),
    .ram_rd(ram_rd), .ram_addr(ram_addr), .ram_data(ram_data), .en_rd(en_rd),
    .data_RGB(data_RGB), .ack(ack), .reset_everloop(reset_everloop),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  initial for (int k = 0; k < 256; k++) mem[k] = 8'(8'hA0 + k);
  always @(posedge clk) if (ram_rd) ram_data <= mem[ram_addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  // serializer model: periodic en_rd, optionally followed by one spurious pulse
  initial forever begin
    @(posedge clk);
    #1;
    if (tick >= per - 1) begin
      en_rd = 1; tick = 0; spur_now = spur_req; spur_req = 0;
    end else if (spur_now) begin
      en_rd = 1; spur_now = 0; tick++;
    end else begin
      en_rd = 0; tick++;
    end
  end

  // monitor: pops the scoreboard on every ack and checks protocol timing
  initial forever begin
    @(negedge clk);
    cyc++;
    if (ram_rd) begin
      n_rd++;
      chk("ram_rd_after_en", en_h[0], 1);
    end
    if (!reset_everloop) n_low++;
    if (ack) begin
      n_ack++;
      chk("ack_single", prev_ack, 0);
      chk("ack_latency", en_h[2], 1);
      if (exp_q.size() == 0) chk("unexpected_ack", data_RGB, 32'hFFFF);
      else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        chk("ack_data", data_RGB, e);
        if (e == 8'hA0) chk("rev_fall_on_a0", {prev_rev, reset_everloop}, 2'b10);
        else chk("rev_low", reset_everloop, 0);
      end
    end
    if (reset_everloop === 1'b1 && prev_rev === 1'b0 && !rst_prev) begin
      rise_cyc = cyc;
      chk("rev_rise_after_en", en_h[0], 1);
    end
    if (frame_done) begin
      n_fd++;
      chk("latch_len", cyc - rise_cyc, LC);
      chk("rev_high_at_done", reset_everloop, 1);
    end
    en_h = {en_h[1:0], en_rd};
    prev_ack = ack;
    prev_rev = reset_everloop;
    rst_prev = rst;
  end

  task automatic push_frame();
    for (int k = 0; k < FB; k++) exp_q.push_back(8'(8'hA0 + k));
    exp_frames++;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
  endtask

  task automatic wait_done(input int lim);
    int k = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && k < lim) begin
      @(negedge clk); k++;
    end
    chk("wait_done", {busy, 31'(exp_q.size())}, 0);
  endtask

  task automatic wait_acks(input int n, input int lim);
    int k = 0;
    while (n_ack < n && k < lim) begin
      @(negedge clk); k++;
    end
    chk("wait_acks", n_ack, n);
  endtask

  initial begin
    int a0, f0, r0, l0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ram_rd", ram_rd, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_data", data_RGB, 0);
    chk("rst_ack", ack, 0);
    chk("rst_rev", reset_everloop, 1);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    rst = 0;
    // single frame at the real serializer pace
    a0 = n_ack; f0 = n_fd;
    push_frame();
    pulse_start();
    chk("busy_after_start", busy, 1);
    wait_done(30000);
    chk("single_acks", n_ack - a0, FB);
    chk("single_frames", n_fd - f0, 1);
    chk("single_idle", busy, 0);
    per = 24;
    // no start: en_rd must be ignored
    a0 = n_ack; r0 = n_rd; l0 = n_low;
    repeat (5 * per) @(negedge clk);
    chk("nostart_rd", n_rd - r0, 0);
    chk("nostart_ack", n_ack - a0, 0);
    chk("nostart_rev_low", n_low - l0, 0);
    // auto refresh: two identical frames back to back
    a0 = n_ack; f0 = n_fd;
    auto_refresh = 1;
    push_frame(); push_frame();
    pulse_start();
    wait_acks(a0 + FB + 1, 5000);
    auto_refresh = 0;
    wait_done(5000);
    chk("auto_acks", n_ack - a0, 2 * FB);
    chk("auto_frames", n_fd - f0, 2);
    // two starts mid-frame merge into one extra frame
    a0 = n_ack; f0 = n_fd;
    push_frame(); push_frame();
    pulse_start();
    wait_acks(a0 + 2, 2000);
    pulse_start();
    wait_acks(a0 + 4, 2000);
    pulse_start();
    wait_done(5000);
    chk("dbl_frames", n_fd - f0, 2);
    a0 = n_ack;
    repeat (5 * per) @(negedge clk);
    chk("dbl_then_idle", n_ack - a0, 0);
    // reset after the third ack aborts the frame
    a0 = n_ack;
    push_frame();
    pulse_start();
    wait_acks(a0 + 3, 2000);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    exp_q.delete();
    exp_frames--;
    chk("abort_rev", reset_everloop, 1);
    chk("abort_busy", busy, 0);
    chk("abort_addr", ram_addr, 0);
    a0 = n_ack;
    repeat (5 * per) @(negedge clk);
    chk("abort_no_ack", n_ack - a0, 0);
    push_frame();
    pulse_start();
    wait_done(5000);
    // spurious en_rd right after a STREAM request
    a0 = n_ack;
    push_frame();
    pulse_start();
    wait_acks(a0 + 1, 2000);
    spur_req = 1;
    wait_done(5000);
    chk("spur_acks", n_ack - a0, FB);
    chk("frames_total", n_fd, exp_frames);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
